lc2k_mem_arbiter: RTL and testbench

Arbitrates the LC2K core's single data-memory array between two requesters: the instruction-fetch stage and the load/store (data) stage. It sits between the pipeline and the memory, and sequences one access at a time. For each access it grants a requester, registers the address, write enable and write data, and drives the memory strobe until the memory acknowledges. It then returns read data with a one-cycle done pulse. A watchdog aborts any access the memory fails to acknowledge in time.

---
 rtl/lc2k_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_lc2k_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc2k_mem_arbiter.sv
// Two-requester arbiter for the LC2K data memory: fetch and load/store share one array.
// One access in flight at a time, round-robin on ties, watchdog abort on a missing mem_ack.
module lc2k_mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {REQ_FETCH, REQ_DATA} requester_t;

  state_t            state;
  requester_t        last_grant;
  requester_t        owner;
  logic [WDOG_W-1:0] wdog;

  logic if_elig;
  logic d_elig;
  logic pick_data;

  // A requester still holding req during its own done cycle is not re-granted.
  assign if_elig   = if_req & ~if_done;
  assign d_elig    = d_req & ~d_done;
  assign pick_data = d_elig & (~if_elig | (last_grant == REQ_FETCH));

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values; blocking would make ordering matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_FETCH;
      owner      <= REQ_FETCH;
      wdog       <= '0;
      if_gnt     <= 1'b0;
      if_done    <= 1'b0;
      if_rdata   <= '0;
      d_gnt      <= 1'b0;
      d_done     <= 1'b0;
      d_rdata    <= '0;
      err        <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt  <= 1'b0;
      d_gnt   <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;

      case (state)
        IDLE: begin
          if (if_elig || d_elig) begin
            mem_en <= 1'b1;
            wdog   <= '0;
            state  <= ACCESS;
            if (pick_data) begin
              owner      <= REQ_DATA;
              last_grant <= REQ_DATA;
              d_gnt      <= 1'b1;
              mem_we     <= d_we;
              mem_addr   <= d_addr;
              mem_wdata  <= d_wdata;
            end else begin
              owner      <= REQ_FETCH;
              last_grant <= REQ_FETCH;
              if_gnt     <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
            end
          end
        end

        ACCESS: begin
          if (mem_ack) begin
            mem_en <= 1'b0;
            state  <= IDLE;
            if (owner == REQ_DATA) begin
              d_done <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (wdog == WDOG_LAST) begin
            // Abort: done+err to the owner, its read data left untouched.
            mem_en <= 1'b0;
            err    <= 1'b1;
            state  <= IDLE;
            if (owner == REQ_DATA) d_done  <= 1'b1;
            else                   if_done <= 1'b1;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc2k_mem_arbiter.sv
// Directed bench for lc2k_mem_arbiter: vector table of single accesses plus
// hand-written tie, held-request and reset-mid-access sequences.
module tb_lc2k_mem_arbiter;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 4;
  localparam logic [DATA_W-1:0] IDLE_RDATA = 32'hBAD0_BAD0;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_gnt, if_done;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_gnt, d_done;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              err, mem_en, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] mem_model [0:255];

  typedef struct {
    logic              is_data;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                ack_at;    // ACCESS cycle carrying mem_ack, 0 = never
    int                exp_en;
    logic              exp_err;
    logic [DATA_W-1:0] exp_d_rdata;
    logic [DATA_W-1:0] exp_if_rdata;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  lc2k_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_ack();
    mem_ack = 1'b1;
    if (mem_we) begin
      mem_model[mem_addr[7:0]] = mem_wdata;
      mem_rdata = 32'hDEAD_BEEF;
    end else begin
      mem_rdata = mem_model[mem_addr[7:0]];
    end
  endtask

  task automatic release_ack();
    mem_ack   = 1'b0;
    mem_rdata = IDLE_RDATA;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_gnt"}, if_gnt, 0);
    check({tag, "_if_done"}, if_done, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_gnt"}, d_gnt, 0);
    check({tag, "_d_done"}, d_done, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic run_access(input vec_t v, input int idx);
    string tag;
    bit    got;
    bit    done_seen;
    int    en_cycles;
    tag = $sformatf("v%0d", idx);
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = v.is_data ? d_gnt : if_gnt;
    end
    check({tag, "_gnt"}, got, 1);
    if (!got) begin
      d_req = 1'b0; if_req = 1'b0;
      return;
    end
    check({tag, "_mem_addr"}, mem_addr, v.addr);
    check({tag, "_mem_we"}, mem_we, v.is_data & v.we);
    if (v.is_data && v.we) check({tag, "_mem_wdata"}, mem_wdata, v.wdata);
    en_cycles = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      if (mem_en) en_cycles++;
      if (mem_en && en_cycles == v.ack_at) drive_ack();
      @(negedge clk);
      release_ack();
      done_seen = v.is_data ? d_done : if_done;
    end
    check({tag, "_done"}, done_seen, 1);
    check({tag, "_other_done"}, v.is_data ? if_done : d_done, 0);
    check({tag, "_err"}, err, v.exp_err);
    check({tag, "_en_cycles"}, en_cycles, v.exp_en);
    check({tag, "_d_rdata"}, d_rdata, v.exp_d_rdata);
    check({tag, "_if_rdata"}, if_rdata, v.exp_if_rdata);
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, v.is_data ? d_done : if_done, 0);
    check({tag, "_err_pulse"}, err, 0);
  endtask

  // Fetch at addr 1 and data load at addr 2 raised together.
  task automatic run_tie(input bit data_first, input string tag);
    if_req = 1'b1; if_addr = 16'd1;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 16'd2;
    @(negedge clk);
    check({tag, "_first_d_gnt"}, d_gnt, data_first);
    check({tag, "_first_if_gnt"}, if_gnt, !data_first);
    check({tag, "_first_addr"}, mem_addr, data_first ? 16'd2 : 16'd1);
    drive_ack();
    @(negedge clk);
    release_ack();
    check({tag, "_first_done"}, data_first ? d_done : if_done, 1);
    check({tag, "_no_gnt_in_done"}, data_first ? if_gnt : d_gnt, 0);
    if (data_first) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    check({tag, "_second_gnt"}, data_first ? if_gnt : d_gnt, 1);
    check({tag, "_second_addr"}, mem_addr, data_first ? 16'd1 : 16'd2);
    drive_ack();
    @(negedge clk);
    release_ack();
    check({tag, "_second_done"}, data_first ? if_done : d_done, 1);
    if_req = 1'b0; d_req = 1'b0;
    check({tag, "_d_rdata"}, d_rdata, 32'h0000_1002);
    check({tag, "_if_rdata"}, if_rdata, 32'h0000_1001);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h0000_1000 + i;
    mem_model[5]  = 32'h0000_002A;
    mem_model[9]  = 32'h0000_0099;

    vecs[0] = '{1'b1, 1'b0, 16'd5,  32'h0,         3, 3, 1'b0, 32'h0000_002A, 32'h0000_0099};
    vecs[1] = '{1'b1, 1'b1, 16'd7,  32'h1234_5678, 1, 1, 1'b0, 32'h0000_002A, 32'h0000_0099};
    vecs[2] = '{1'b1, 1'b0, 16'd7,  32'h0,         2, 2, 1'b0, 32'h1234_5678, 32'h0000_0099};
    vecs[3] = '{1'b0, 1'b0, 16'd10, 32'h0,         1, 1, 1'b0, 32'h1234_5678, 32'h0000_100A};
    vecs[4] = '{1'b0, 1'b0, 16'd3,  32'h0,         0, 4, 1'b1, 32'h1234_5678, 32'h0000_100A};
    vecs[5] = '{1'b1, 1'b0, 16'd5,  32'h0,         4, 4, 1'b0, 32'h0000_002A, 32'h0000_100A};
    vecs[6] = '{1'b1, 1'b1, 16'd8,  32'hCAFE_F00D, 0, 4, 1'b1, 32'h0000_002A, 32'h0000_100A};

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = IDLE_RDATA;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_tie(1'b1, "tie1");

    // Data request held through its done while fetch waits.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd5;
    @(negedge clk);
    check("held_d_gnt", d_gnt, 1);
    if_req = 1'b1; if_addr = 16'd9;
    drive_ack();
    @(negedge clk);
    release_ack();
    check("held_d_done", d_done, 1);
    check("held_d_rdata", d_rdata, 32'h0000_002A);
    @(negedge clk);
    check("held_if_gnt", if_gnt, 1);
    check("held_no_dup_d_gnt", d_gnt, 0);
    check("held_fetch_addr", mem_addr, 16'd9);
    d_req = 1'b0;
    drive_ack();
    @(negedge clk);
    release_ack();
    check("held_if_done", if_done, 1);
    check("held_if_rdata", if_rdata, 32'h0000_0099);
    if_req = 1'b0;
    @(negedge clk);
    check("held_idle_d_gnt", d_gnt, 0);
    check("held_idle_mem_en", mem_en, 0);

    for (int i = 0; i < 7; i++) run_access(vecs[i], i);

    // Last grant was data, so this tie goes to fetch.
    run_tie(1'b0, "tie2");

    // Reset in the second ACCESS cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd5;
    @(negedge clk);
    check("rst_mid_d_gnt", d_gnt, 1);
    @(negedge clk);
    check("rst_mid_mem_en_before", mem_en, 1);
    #1 reset = 1'b1;
    #1 check_all_zero("rst_mid");
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_mid_no_done%0d", i), d_done, 0);
    end

    run_tie(1'b1, "tie3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
